// File: rtl/tdc_frame_packer.sv
// tdc_frame_packer: groups 12-byte TDC records into SYNC0/SYNC1/SEQ-headed frames closed by a COUNT trailer.
// Optional feature: define TDC_FRAME_PACKER_CHECKSUM_EN to append a zero-sum CSUM byte after COUNT.
module tdc_frame_packer #(
    parameter int         MAX_RECS       = 16,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC0          = 8'hA5,
    parameter logic [7:0] SYNC1          = 8'h5A
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_s_axis_tdata,
    input  logic       i_s_axis_tkeep,
    input  logic       i_s_axis_tvalid,
    output logic       o_s_axis_tready,
    input  logic       i_s_axis_tlast,
    output logic [7:0] o_m_axis_tdata,
    output logic       o_m_axis_tvalid,
    input  logic       i_m_axis_tready,
    output logic       o_m_axis_tlast,
    input  logic       i_flush,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_H0, ST_H1, ST_SEQ, ST_PAY, ST_CNT, ST_CSUM
    } state_t;

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       MAX_RC   = 8'(MAX_RECS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [7:0]       seq, rc, rc_inc;
    logic [TMR_W-1:0] tmr;
    logic             flush_flag, mid_rec;
    logic             can_load, tmr_cnt, tmr_fire, close_bnd, close_rec, acc_in, acc_last;
    logic             ld_en, ld_last;
    logic [7:0]       ld_data;

`ifdef TDC_FRAME_PACKER_CHECKSUM_EN
    logic [7:0] csum_acc;

    function automatic logic [7:0] zero_sum_byte(input logic [7:0] acc);
        return 8'd0 - acc;
    endfunction
`endif

    assign can_load  = !o_m_axis_tvalid || i_m_axis_tready;
    assign rc_inc    = rc + 8'd1;
    // Idle timer only runs between records of a non-empty frame with the input quiet.
    assign tmr_cnt   = (state == ST_PAY) && !mid_rec && (rc != 8'd0) && !i_s_axis_tvalid;
    assign tmr_fire  = tmr_cnt && (tmr == TMR_LAST);
    assign close_bnd = (state == ST_PAY) && !mid_rec && (rc != 8'd0) && (flush_flag || tmr_fire);
    assign o_s_axis_tready = (state == ST_PAY) && can_load && !close_bnd;
    assign acc_in    = o_s_axis_tready && i_s_axis_tvalid;
    assign acc_last  = acc_in && i_s_axis_tlast;
    assign close_rec = acc_last && ((rc_inc == MAX_RC) || flush_flag || i_flush);
    assign o_busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        ld_en     = 1'b0;
        ld_data   = 8'h00;
        ld_last   = 1'b0;
        case (state)
            ST_IDLE: if (i_s_axis_tvalid) state_nxt = ST_H0;
            ST_H0: if (can_load) begin
                ld_en = 1'b1; ld_data = SYNC0; state_nxt = ST_H1;
            end
            ST_H1: if (can_load) begin
                ld_en = 1'b1; ld_data = SYNC1; state_nxt = ST_SEQ;
            end
            ST_SEQ: if (can_load) begin
                ld_en = 1'b1; ld_data = seq; state_nxt = ST_PAY;
            end
            ST_PAY: begin
                if (acc_in && i_s_axis_tkeep) begin
                    ld_en = 1'b1; ld_data = i_s_axis_tdata;
                end
                if (close_rec || close_bnd) state_nxt = ST_CNT;
            end
            ST_CNT: if (can_load) begin
                ld_en   = 1'b1;
                ld_data = rc;
`ifdef TDC_FRAME_PACKER_CHECKSUM_EN
                state_nxt = ST_CSUM;
`else
                ld_last   = 1'b1;
                state_nxt = ST_IDLE;
`endif
            end
`ifdef TDC_FRAME_PACKER_CHECKSUM_EN
            ST_CSUM: if (can_load) begin
                ld_en = 1'b1; ld_data = zero_sum_byte(csum_acc); ld_last = 1'b1; state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output register stage: loads only when empty or draining, so a stalled byte never changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= 8'h00;
            o_m_axis_tlast  <= 1'b0;
        end else if (can_load) begin
            o_m_axis_tvalid <= ld_en;
            if (ld_en) begin
                o_m_axis_tdata <= ld_data;
                o_m_axis_tlast <= ld_last;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            seq        <= 8'd0;
            rc         <= 8'd0;
            mid_rec    <= 1'b0;
            tmr        <= '0;
            flush_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_en && ld_last) seq <= seq + 8'd1;
            if (state_nxt == ST_IDLE) rc <= 8'd0;
            else if (acc_last)        rc <= rc_inc;
            if (acc_in) mid_rec <= !i_s_axis_tlast;
            if (acc_in || state != ST_PAY) tmr <= '0;
            else if (tmr_cnt)              tmr <= tmr + TMR_W'(1);
            // A flush with nothing to close (idle, or between records of an empty frame) is dropped.
            if (state == ST_IDLE || (state == ST_PAY && state_nxt == ST_CNT)) flush_flag <= 1'b0;
            else if (i_flush) flush_flag <= (rc != 8'd0) || mid_rec;
        end
    end

`ifdef TDC_FRAME_PACKER_CHECKSUM_EN
    // Sum covers SEQ, kept payload and COUNT; sync bytes are excluded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              csum_acc <= 8'd0;
        else if (state == ST_IDLE) csum_acc <= 8'd0;
        else if (ld_en && (state == ST_SEQ || state == ST_PAY || state == ST_CNT))
            csum_acc <= csum_acc + ld_data;
    end
`endif

endmodule

// File: tb/tb_tdc_frame_packer.sv
// Bench for tdc_frame_packer: random records against a frame-level reference model built from queues.
`timescale 1ns/1ps
module tb_tdc_frame_packer;
    localparam int MAX_RECS       = 2;
    localparam int TIMEOUT_CYCLES = 50;
`ifdef TDC_FRAME_PACKER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tkeep, s_tvalid, s_tready, s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tready, m_tlast;
    logic       flush, busy;

    int   n_chk = 0, n_err = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;
    int   last_in_cyc = 0;
    logic [8:0] got_q[$];
    int         got_cyc[$];
    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] m_seq;
    int         m_rc;
    bit         m_flush;
    bit         stall_prev = 1'b0;
    logic [8:0] stall_val;

    tdc_frame_packer #(
        .MAX_RECS(MAX_RECS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC0(8'hA5), .SYNC1(8'h5A)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_axis_tdata(s_tdata), .i_s_axis_tkeep(s_tkeep), .i_s_axis_tvalid(s_tvalid),
        .o_s_axis_tready(s_tready), .i_s_axis_tlast(s_tlast),
        .o_m_axis_tdata(m_tdata), .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
        .o_m_axis_tlast(m_tlast), .i_flush(flush), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: records handshakes and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev)
                chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, stall_val}));
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tlast, m_tdata});
                got_cyc.push_back(cyc);
            end
            if (s_tvalid && s_tready && s_tlast) last_in_cyc = cyc;
            stall_prev = m_tvalid && !m_tready;
            stall_val  = {m_tlast, m_tdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: a whole frame is appended once the model decides it closes.
    task automatic model_close();
        logic [7:0] sum;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, m_seq});
        sum = m_seq;
        foreach (pay_q[i]) begin
            exp_q.push_back({1'b0, pay_q[i]});
            sum = sum + pay_q[i];
        end
        sum = sum + 8'(m_rc);
        exp_q.push_back({(CS == 0), 8'(m_rc)});
        if (CS == 1) exp_q.push_back({1'b1, 8'd0 - sum});
        m_seq   = m_seq + 8'd1;
        pay_q.delete();
        m_rc    = 0;
        m_flush = 1'b0;
    endtask

    task automatic send_rec(input int nbytes, input logic [11:0] keepm, input int flush_at, input int max_gap);
        bit acc;
        int t;
        for (int i = 0; i < nbytes; i++) begin
            int gap;
            gap = int'($urandom_range(0, max_gap));
            if (gap > 0) begin
                s_tvalid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            s_tvalid = 1'b1;
            s_tdata  = 8'($urandom);
            s_tkeep  = keepm[i];
            s_tlast  = (i == 11);
            if (i == flush_at) begin flush = 1'b1; m_flush = 1'b1; end
            acc = 1'b0;
            t = 0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                flush = 1'b0;
                t++;
            end
            chk("s_accept", 32'(acc), 32'd1);
            if (keepm[i]) pay_q.push_back(s_tdata);
            if (i == 11) begin
                m_rc++;
                if (m_rc == MAX_RECS || m_flush) model_close();
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        s_tvalid = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || m_tvalid) && t < 2000);
        chk($sformatf("%s_drain", tag), 32'(t < 2000), 32'd1);
        if (m_rc > 0) model_close();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_frames(input string tag);
        int e0;
        chk($sformatf("%s_len", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            e0 = n_err;
            chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            if (n_err != e0) break;
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic model_reset();
        m_seq = 8'd0; m_rc = 0; m_flush = 1'b0;
        pay_q.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s_m_tvalid", tag), 32'(m_tvalid), 32'd0);
        chk($sformatf("%s_m_tlast", tag),  32'(m_tlast),  32'd0);
        chk($sformatf("%s_m_tdata", tag),  32'(m_tdata),  32'd0);
        chk($sformatf("%s_s_tready", tag), 32'(s_tready), 32'd0);
        chk($sformatf("%s_busy", tag),     32'(busy),     32'd0);
    endtask

    initial begin
        int idx;
        logic [11:0] km;
        int fa;
        rst_n = 1'b0; s_tdata = 8'h00; s_tkeep = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        flush = 1'b0; m_tready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two records close the frame on the record limit.
        send_rec(12, 12'hFFF, -1, 0);
        send_rec(12, 12'hFFF, -1, 0);
        wait_drain("cnt");
        chk("cnt_total", got_q.size(), 28 + CS);
        if (got_q.size() >= 3) chk("cnt_seq0", 32'(got_q[2]), 32'h000);
        cmp_frames("cnt");

        // One record then idle: timeout close and trailer latency.
        send_rec(12, 12'hFFF, -1, 0);
        @(negedge clk);
        chk("to_busy_open", 32'(busy), 32'd1);
        wait_drain("to");
        chk("to_busy_after", 32'(busy), 32'd0);
        idx = got_q.size() - 1 - CS;
        if (idx >= 1) begin
            chk("to_count", 32'(got_q[idx][7:0]), 32'd1);
            chk("to_cnt_lat", got_cyc[idx] - last_in_cyc, 32'd52);
            chk("to_pay_lat", got_cyc[idx - 1] - last_in_cyc, 32'd1);
            chk("to_seq1", 32'(got_q[2][7:0]), 32'd1);
        end else begin
            chk("to_len_min", got_q.size(), 32'd2 + CS);
        end
        cmp_frames("to");

        // Flush mid-record closes at that record's end.
        send_rec(12, 12'hFFF, 5, 0);
        wait_drain("fl");
        if (got_q.size() > 15) chk("fl_count", 32'(got_q[15][7:0]), 32'd1);
        else chk("fl_len_min", got_q.size(), 32'd16);
        cmp_frames("fl");
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("idle_flush_out", got_q.size(), 32'd0);
        chk("idle_flush_busy", 32'(busy), 32'd0);
        send_rec(12, 12'hFFF, -1, 0);
        send_rec(12, 12'hFFF, -1, 0);
        wait_drain("post_fl");
        cmp_frames("post_fl");

        // tkeep=0 on bytes 0..3: dropped but record still counted.
        send_rec(12, 12'hFF0, -1, 0);
        send_rec(12, 12'hFFF, -1, 0);
        wait_drain("keep");
        chk("keep_total", got_q.size(), 3 + 8 + 12 + 1 + CS);
        cmp_frames("keep");

        // Random data, keep, gaps, flushes and sink backpressure.
        rdy_rand = 1'b1;
        for (int r = 0; r < 24; r++) begin
            km = 12'($urandom);
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
            send_rec(12, km, fa, 3);
        end
        wait_drain("rnd");
        cmp_frames("rnd");
        rdy_rand = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // 256 frames so SEQ wraps FF -> 00.
        for (int f = 0; f < 256; f++) begin
            send_rec(12, 12'hFFF, -1, 0);
            send_rec(12, 12'hFFF, -1, 0);
        end
        wait_drain("wrap");
        cmp_frames("wrap");

        // Reset mid-payload, then a clean frame from SEQ 0.
        send_rec(6, 12'hFFF, -1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        send_rec(12, 12'hFFF, -1, 0);
        send_rec(12, 12'hFFF, -1, 0);
        wait_drain("rst2");
        if (got_q.size() >= 3) begin
            chk("rst2_sync0", 32'(got_q[0]), 32'h0A5);
            chk("rst2_sync1", 32'(got_q[1]), 32'h05A);
            chk("rst2_seq",   32'(got_q[2]), 32'h000);
        end else begin
            chk("rst2_len_min", got_q.size(), 32'd3);
        end
        cmp_frames("rst2");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
